irq_controller: RTL and testbench

- Memory-mapped interrupt controller for the P7 CPU; sits on the data bus beside the bridge.
- Synchronises up to NUM_SRC asynchronous device interrupt lines and latches rising edges as pending bits.
- Applies a software mask and drives the CPU's single `interrupt` input for one source at a time, in priority order.
- The handler acknowledges a source by storing to BASE_ADDR (0x7F20), which clears that source and lowers `interrupt`.

---
 rtl/irq_controller_if.sv | 21 ++
 rtl/irq_controller.sv | 174 +++++++++++++++++
 tb/tb_irq_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - CPU data-bus bundle between the P7 core and irq_controller
interface irq_controller_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    output m_data_rdata
  );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latching priority interrupt controller (optional COUNT register: IRQ_COUNT_EN)
module irq_controller #(
  parameter int          NUM_SRC     = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F20,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  irq_controller_if.slave    bus,
  output logic               interrupt,
  output logic [3:0]         irq_id
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ASSERT  = 4'd1,
    ST_HOLDOFF = 4'd2
  } state_t;

  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] mask_q;
  state_t             state_q;
  state_t             state_d;
  logic               int_d;
  logic [3:0]         id_d;
  logic               ack_leave;

  logic [NUM_SRC-1:0] sync_out;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] cur_sel;
  logic [3:0]         win_id;
  logic [31:0]        bm;
  logic [31:0]        wdata_m;
  logic [29:0]        word_off;
  logic               in_win;
  logic               wr;
  logic               ack_wr;
  logic               mask_wr;
  logic               cnt_wr;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] mask_new;
  logic [31:0]        count_rd;
  logic               unused_bits;

  // Address decode and byte-lane merge of store data
  always_comb begin
    bm       = {{8{bus.m_data_byteen[3]}}, {8{bus.m_data_byteen[2]}},
                {8{bus.m_data_byteen[1]}}, {8{bus.m_data_byteen[0]}}};
    wdata_m  = bus.m_data_wdata & bm;
    word_off = bus.m_data_addr[31:2] - BASE_ADDR[31:2];
    in_win   = (word_off < 30'd4);
    wr       = |bus.m_data_byteen;
    ack_wr   = wr && in_win && (word_off[1:0] == 2'd0);
    mask_wr  = wr && in_win && (word_off[1:0] == 2'd1);
    cnt_wr   = wr && in_win && (word_off[1:0] == 2'd3);
    ack_clr  = ack_wr ? wdata_m[NUM_SRC-1:0] : '0;
    mask_new = (mask_q & ~bm[NUM_SRC-1:0]) | wdata_m[NUM_SRC-1:0];
  end

  assign unused_bits = ^{bus.m_data_addr[1:0], wdata_m[31:NUM_SRC], bm[31:NUM_SRC]};

  // Input synchroniser chain and one-clock edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;

  // Pending bits: a new edge wins over a simultaneous ACK clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= (pending_q & ~ack_clr) | rise;
  end

  // Software mask register with per-lane merge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mask_q <= '1;
    else if (mask_wr) mask_q <= mask_new;
  end

  // Lowest-index enabled pending source wins
  always_comb begin
    req    = pending_q & mask_q;
    win_id = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_id = 4'(i);
    end
  end

  assign cur_sel = ONE << irq_id;

  // FSM state register with registered interrupt and irq_id outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      interrupt <= 1'b0;
      irq_id    <= 4'd0;
    end else begin
      state_q   <= state_d;
      interrupt <= int_d;
      irq_id    <= id_d;
    end
  end

  // FSM next state; HOLDOFF forwards straight to the next winner so the low gap is one clock
  always_comb begin
    state_d   = state_q;
    ack_leave = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLDOFF: state_d = (|req) ? ST_ASSERT : ST_IDLE;
      ST_ASSERT: begin
        if (|(ack_clr & cur_sel)) begin
          state_d   = ST_HOLDOFF;
          ack_leave = 1'b1;
        end else if (!(|(mask_q & cur_sel))) begin
          state_d = ST_HOLDOFF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: raise in ASSERT, capture the winner only on entry
  always_comb begin
    int_d = (state_d == ST_ASSERT);
    id_d  = irq_id;
    if (state_q != ST_ASSERT && state_d == ST_ASSERT) id_d = win_id;
  end

`ifdef IRQ_COUNT_EN
  logic [31:0] count_q;

  // Count ACK-terminated interrupts; any store to COUNT clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         count_q <= 32'd0;
    else if (cnt_wr)    count_q <= 32'd0;
    else if (ack_leave) count_q <= count_q + 32'd1;
  end

  assign count_rd = count_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_wr ^ ack_leave;
  assign count_rd   = 32'd0;
`endif

  // Combinational register read mux, zero outside the window
  always_comb begin
    bus.m_data_rdata = 32'd0;
    if (in_win) begin
      case (word_off[1:0])
        2'd0:    bus.m_data_rdata = 32'(pending_q);
        2'd1:    bus.m_data_rdata = 32'(mask_q);
        2'd2:    bus.m_data_rdata = {interrupt, 23'd0, state_q, irq_id};
        default: bus.m_data_rdata = count_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;
  localparam logic [31:0] A_ACK  = 32'h7F20;
  localparam logic [31:0] A_MASK = 32'h7F24;
  localparam logic [31:0] A_STAT = 32'h7F28;
  localparam logic [31:0] A_CNT  = 32'h7F2C;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] irq_src;
  logic       interrupt;
  logic [3:0] irq_id;
  int         total = 0;
  int         passed = 0;

  irq_controller_if bus ();

  irq_controller #(.NUM_SRC(6), .BASE_ADDR(32'h0000_7F20), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus       (bus.slave),
    .interrupt (interrupt),
    .irq_id    (irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = data;
    bus.m_data_byteen = be;
    step(1);
    bus.m_data_byteen = 4'b0000;
    bus.m_data_wdata  = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.m_data_addr = addr;
    #1;
    data = bus.m_data_rdata;
  endtask

  task automatic wait_irq(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step(1);
      if (interrupt === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse(input logic [5:0] bits);
    irq_src = bits;
    step(1);
    irq_src = 6'd0;
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    logic        stayed_low;
    logic [31:0] exp_cnt;

    vecs[0]  = '{1'b0, 32'h0, 32'h0, 4'h0, A_ACK,        32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0, 32'h0, 4'h0, A_MASK,       32'h0000_003F};
    vecs[2]  = '{1'b0, 32'h0, 32'h0, 4'h0, A_STAT,       32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0, 32'h0, 4'h0, A_CNT,        32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h7F30,     32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h7F1C,     32'h0000_0000};
    vecs[6]  = '{1'b1, A_MASK, 32'h0000_0005, 4'b0001, A_MASK, 32'h0000_0005};
    vecs[7]  = '{1'b1, A_MASK, 32'hFFFF_FF00, 4'b0001, A_MASK, 32'h0000_0000};
    vecs[8]  = '{1'b1, A_MASK, 32'h0000_003A, 4'b0010, A_MASK, 32'h0000_0000};
    vecs[9]  = '{1'b1, A_MASK, 32'hFFFF_FFFF, 4'b1111, 32'h7F25, 32'h0000_003F};
    vecs[10] = '{1'b1, A_STAT, 32'h0000_00FF, 4'b1111, A_STAT, 32'h0000_0000};
    vecs[11] = '{1'b1, A_CNT,  32'h1234_5678, 4'b1111, A_CNT,  32'h0000_0000};
    vecs[12] = '{1'b1, A_ACK,  32'hFFFF_FFFF, 4'b1111, A_ACK,  32'h0000_0000};

    reset = 1'b0;
    irq_src = 6'd0;
    bus.m_data_addr = 32'd0;
    bus.m_data_wdata = 32'd0;
    bus.m_data_byteen = 4'd0;
    step(3);
    reset = 1'b1;
    step(1);
    check("reset_interrupt", {31'd0, interrupt}, 32'd0);
    check("reset_irq_id", {28'd0, irq_id}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      bus_read(vecs[i].raddr, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    irq_src[2] = 1'b1;
    wait_irq(10, n);
    check("src2_latency", 32'(n), 32'd4);
    check("src2_id", {28'd0, irq_id}, 32'd2);
    bus_read(A_ACK, rd);
    check("src2_pending", rd, 32'h0000_0004);
    bus_read(A_STAT, rd);
    check("src2_status", rd, 32'h8000_0012);

    bus_write(A_ACK, 32'h0000_0004, 4'b1111);
    check("ack_drop", {31'd0, interrupt}, 32'd0);
    stayed_low = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (interrupt !== 1'b0) stayed_low = 1'b0;
    end
    check("held_no_retrigger", {31'd0, stayed_low}, 32'd1);
    bus_read(A_ACK, rd);
    check("held_pending", rd, 32'h0);
    irq_src[2] = 1'b0;
    step(4);

    pulse(6'b010010);
    wait_irq(10, n);
    check("pair_seen", {31'd0, n > 0}, 32'd1);
    check("pair_first_id", {28'd0, irq_id}, 32'd1);
    bus_read(A_ACK, rd);
    check("pair_pending", rd, 32'h0000_0012);
    bus_write(A_ACK, 32'h0000_0002, 4'b1111);
    check("pair_gap_low", {31'd0, interrupt}, 32'd0);
    step(1);
    check("pair_second_high", {31'd0, interrupt}, 32'd1);
    check("pair_second_id", {28'd0, irq_id}, 32'd4);
    bus_write(A_ACK, 32'h0000_0010, 4'b1111);
    step(3);
    check("pair_done", {31'd0, interrupt}, 32'd0);

    bus_write(A_MASK, 32'h0000_003E, 4'b1111);
    pulse(6'b000001);
    stayed_low = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (interrupt !== 1'b0) stayed_low = 1'b0;
    end
    check("masked_low", {31'd0, stayed_low}, 32'd1);
    bus_read(A_ACK, rd);
    check("masked_pending", rd, 32'h0000_0001);
    bus_write(A_MASK, 32'h0000_003F, 4'b1111);
    step(1);
    check("unmask_high", {31'd0, interrupt}, 32'd1);
    check("unmask_id", {28'd0, irq_id}, 32'd0);
    bus_write(A_ACK, 32'h0000_0020, 4'b1111);
    step(1);
    check("other_ack_holds", {31'd0, interrupt}, 32'd1);
    bus_write(A_MASK, 32'h0000_003E, 4'b1111);
    step(1);
    check("mask_drop", {31'd0, interrupt}, 32'd0);
    bus_read(A_ACK, rd);
    check("mask_drop_pending", rd, 32'h0000_0001);
    bus_write(A_MASK, 32'h0000_003F, 4'b1111);
    step(2);
    check("remask_high", {31'd0, interrupt}, 32'd1);

    #2;
    reset = 1'b0;
    #1;
    check("async_reset_drop", {31'd0, interrupt}, 32'd0);
    #1;
    reset = 1'b1;
    step(1);
    bus_read(A_ACK, rd);
    check("post_reset_pending", rd, 32'h0);
    bus_read(A_MASK, rd);
    check("post_reset_mask", rd, 32'h0000_003F);

    for (int j = 0; j < 3; j++) begin
      pulse(6'b001000);
      wait_irq(10, n);
      check($sformatf("cnt_irq%0d", j), {28'd0, irq_id}, 32'd3);
      bus_write(A_ACK, 32'h0000_0008, 4'b1111);
      step(2);
    end
`ifdef IRQ_COUNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    bus_read(A_CNT, rd);
    check("count_three", rd, exp_cnt);
    bus_write(A_CNT, 32'h0, 4'b0001);
    bus_read(A_CNT, rd);
    check("count_cleared", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
